// File: rtl/keypad_scan4x4_if.sv
// Keypad scanner bus: the keypad matrix lines plus the decoded key outputs.
//   master : the scanner. It samples KEY_COL and drives KEY_ROW, KEY_VALUE,
//            KEY_VALID and KEY_PRESSED.
//   slave  : the keypad/consumer side. It drives KEY_COL and sees the rest.
// KEY_COL  : column sense, active-low, asynchronous to the scanner clock.
// KEY_ROW  : row drive, one-hot active-low.
// KEY_VALUE: last accepted key code 0..F.
// KEY_VALID: one-cycle strobe meaning a new code is on KEY_VALUE.
// KEY_PRESSED: debounced key-held level.
interface keypad_scan4x4_if;
  logic [3:0] KEY_COL;
  logic [3:0] KEY_ROW;
  logic [3:0] KEY_VALUE;
  logic       KEY_VALID;
  logic       KEY_PRESSED;

  modport master (
    input  KEY_COL,
    output KEY_ROW, KEY_VALUE, KEY_VALID, KEY_PRESSED
  );

  modport slave (
    output KEY_COL,
    input  KEY_ROW, KEY_VALUE, KEY_VALID, KEY_PRESSED
  );
endinterface

// File: rtl/keypad_scan4x4.sv
// 4x4 matrix keypad scanner with debounce. It produces hex key codes 0..F for
// the seven-segment display path.
// Ports:
//   CLK_50M : system clock
//   RST_N   : asynchronous active-low reset
//   kp      : keypad_scan4x4_if.master. It carries KEY_COL in, and KEY_ROW,
//             KEY_VALUE, KEY_VALID and KEY_PRESSED out.
// Optional feature: define KEY_REPEAT_EN to enable auto-repeat while a key is
// held. The first repeat comes after REPEAT_DELAY scans. Later repeats come
// every REPEAT_RATE scans.
module keypad_scan4x4 #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 20,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic                     CLK_50M,
  input  logic                     RST_N,
  keypad_scan4x4_if.master         kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_cfg_err
    $error("keypad_scan4x4: SCAN_DIV>=4, DEBOUNCE_SCANS/REPEAT_* >= 1 required");
  end

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  // column synchronizer. The reset value is flushed long before the first
  // sample, because a row is sampled only after SCAN_DIV-1 settle cycles.
  logic [3:0]       col_s1, col_s2;

  logic [DIV_W-1:0] div;
  logic [1:0]       row_idx;
  logic [3:0]       key_row;
  logic [15:0]      snapshot, snap_next;
  logic             tc, scan_done;

  state_t           state;
  logic [3:0]       cand;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [3:0]       key_value;
  logic             key_valid, key_pressed;

  logic             snap_none, snap_single;
  logic [3:0]       snap_code;

  assign kp.KEY_ROW     = key_row;
  assign kp.KEY_VALUE   = key_value;
  assign kp.KEY_VALID   = key_valid;
  assign kp.KEY_PRESSED = key_pressed;

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      col_s1 <= '0;
      col_s2 <= '0;
    end else begin
      col_s1 <= kp.KEY_COL;
      col_s2 <= col_s1;
    end
  end

  assign tc        = (div == DIV_W'(SCAN_DIV - 1));
  assign scan_done = tc && (row_idx == 2'd3);

  // Build the updated snapshot. The current row's slot is overwritten with the
  // inverted columns, so on scan_done this value holds the complete 16-key image.
  always_comb begin
    snap_next = snapshot;
    snap_next[{row_idx, 2'b00} +: 4] = ~col_s2;
  end

  always_comb begin
    snap_code = '0;
    for (int i = 0; i < 16; i++)
      if (snap_next[i]) snap_code = 4'(i);
  end

  assign snap_none   = (snap_next == '0);
  assign snap_single = $onehot(snap_next);

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      div      <= '0;
      row_idx  <= '0;
      key_row  <= 4'b1110;
      snapshot <= '0;
    end else if (tc) begin
      div      <= '0;
      row_idx  <= row_idx + 2'd1;
      key_row  <= {key_row[2:0], key_row[3]};
      snapshot <= snap_next;
    end else begin
      div      <= div + 1'b1;
    end
  end

  assign cnt_inc = (cnt == CNT_W'(DEBOUNCE_SCANS)) ? cnt : cnt + 1'b1;

`ifdef KEY_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_first;   // still waiting for the initial delay
  logic             rpt_hit;
  assign rpt_hit = rpt_first ? (rpt_cnt == RPT_W'(REPEAT_DELAY - 1))
                             : (rpt_cnt == RPT_W'(REPEAT_RATE - 1));
`endif

  // The debounce FSM advances only on scan completion. The outputs are
  // registered, so an accept shows up on the cycle after scan_done.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      cand        <= '0;
      cnt         <= '0;
      key_value   <= '0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_cnt     <= '0;
      rpt_first   <= 1'b1;
`endif
    end else begin
      key_valid <= 1'b0;
      if (scan_done) begin
        case (state)
          IDLE: begin
            if (snap_single) begin
              cand <= snap_code;
              cnt  <= CNT_W'(1);
              if (DEBOUNCE_SCANS == 1) begin
                state       <= HELD;
                key_value   <= snap_code;
                key_valid   <= 1'b1;
                key_pressed <= 1'b1;
`ifdef KEY_REPEAT_EN
                rpt_cnt     <= '0;
                rpt_first   <= 1'b1;
`endif
              end else begin
                state <= PRESS_DB;
              end
            end
          end
          PRESS_DB: begin
            if (snap_single && snap_code == cand) begin
              cnt <= cnt_inc;
              if (cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                state       <= HELD;
                key_value   <= cand;
                key_valid   <= 1'b1;
                key_pressed <= 1'b1;
`ifdef KEY_REPEAT_EN
                rpt_cnt     <= '0;
                rpt_first   <= 1'b1;
`endif
              end
            end else if (snap_single) begin
              cand <= snap_code;
              cnt  <= CNT_W'(1);
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          HELD: begin
            // Only a full release leaves HELD. A second key has no effect
            // (no rollover).
            if (snap_none) begin
              cnt <= CNT_W'(1);
`ifdef KEY_REPEAT_EN
              rpt_cnt   <= '0;
              rpt_first <= 1'b1;
`endif
              if (DEBOUNCE_SCANS == 1) begin
                state       <= IDLE;
                key_pressed <= 1'b0;
              end else begin
                state <= REL_DB;
              end
            end
`ifdef KEY_REPEAT_EN
            else if (rpt_hit) begin
              key_valid <= 1'b1;
              rpt_cnt   <= '0;
              rpt_first <= 1'b0;
            end else begin
              rpt_cnt   <= rpt_cnt + 1'b1;
            end
`endif
          end
          REL_DB: begin
            if (snap_none) begin
              cnt <= cnt_inc;
              if (cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                state       <= IDLE;
                key_pressed <= 1'b0;
                cnt         <= '0;
              end
            end else begin
              state <= HELD;
              cnt   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/keypad_scan4x4.md
Name: keypad_scan4x4

Overview:
- Input-side counterpart to the board's seven-segment output path.
- Scans a 4x4 matrix keypad: drives rows active-low, samples columns, debounces, and emits a 4-bit hex key code 0..F with a one-cycle valid strobe.
- Output feeds the segment display/control logic directly; codes match the display's 0..F digit set.

Parameters:
- SCAN_DIV, 50000, clock cycles each row is driven (1 ms at 50 MHz); min 4.
- DEBOUNCE_SCANS, 20, consecutive identical full-scan snapshots needed to accept a press or release; min 1.
- REPEAT_DELAY, 500, full scans held before first auto-repeat (KEY_REPEAT_EN only).
- REPEAT_RATE, 100, full scans between subsequent repeats (KEY_REPEAT_EN only).

Ports:
- CLK_50M  input  1  system clock.
- RST_N  input  1  asynchronous active-low reset.
- KEY_COL  input  4  column sense, active-low (pulled up externally), asynchronous to CLK_50M.
- KEY_ROW  output  4  row drive, one-hot active-low.
- KEY_VALUE  output  4  last accepted key code.
- KEY_VALID  output  1  one-cycle strobe: new code on KEY_VALUE.
- KEY_PRESSED  output  1  level: debounced key currently held.

Behaviour:
- Interface: single clock CLK_50M; reset RST_N is asynchronous, active-low; all flops clear on RST_N=0 regardless of clock.
- Reset values: KEY_ROW=4'b1110, KEY_VALUE=0, KEY_VALID=0, KEY_PRESSED=0, state=IDLE, all counters=0, snapshot=0.
- KEY_COL passes through a 2-flop synchronizer before any use.
- Row scan:
  - Divider counts 0..SCAN_DIV-1; at terminal count KEY_ROW rotates 1110->1101->1011->0111->1110.
  - Row r driven low means row index r.
- Column sampling:
  - The synchronized columns are sampled on the divider's terminal-count cycle, before rotation, so they have settled for SCAN_DIV-1 cycles.
  - The sample is inverted and stored in snapshot bits [4r+3:4r].
- A full scan completes at terminal count of row 3; the 16-bit snapshot is evaluated then. Scan period = 4*SCAN_DIV cycles.
- Classification:
  - NONE: all zero.
  - SINGLE(k): exactly one bit set, k = 4*row + col, col 0 = KEY_COL[0].
  - MULTI: two or more bits set.
- FSM, evaluated only at scan completion:
  - IDLE:
    - SINGLE(k): capture cand=k, cnt=1, go to PRESS_DB. If DEBOUNCE_SCANS=1, go directly to HELD and accept.
    - NONE or MULTI: stay in IDLE.
  - PRESS_DB:
    - SINGLE(cand): cnt++. When cnt reaches DEBOUNCE_SCANS, accept and go to HELD.
    - SINGLE(other): restart with the new cand, cnt=1.
    - NONE or MULTI: return to IDLE, cnt=0.
  - Accept action: KEY_VALUE<=cand on the cycle after scan completion, KEY_VALID=1 for exactly that one cycle, KEY_PRESSED<=1 on the same cycle.
  - HELD:
    - NONE: cnt=1, go to REL_DB.
    - Any other snapshot, including a different key or MULTI: no effect, no rollover.
  - REL_DB:
    - NONE: cnt++. At DEBOUNCE_SCANS, KEY_PRESSED<=0 and go to IDLE.
    - Any non-NONE snapshot: return to HELD, cnt=0.
- KEY_VALUE holds its value until the next accept; it is never cleared except by reset.
- KEY_VALID is never asserted on two consecutive cycles.
- Reset asserted mid-scan or mid-debounce aborts immediately to reset values; the first post-reset snapshot is built from a fresh row-0 slot.
- Counter widths: the divider is sized by $clog2(SCAN_DIV); debounce and repeat counters saturate and never wrap.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - In HELD, a scan counter runs from entry into HELD.
  - At REPEAT_DELAY scans, KEY_VALID pulses once with KEY_VALUE unchanged.
  - Thereafter it pulses every REPEAT_RATE scans.
  - The counter clears on leaving HELD, including into REL_DB; returning from REL_DB restarts the delay.
- Undefined: exactly one KEY_VALID per accepted press; no repeat counter logic is synthesized.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, scan=16 cycles):
- Reset check: hold RST_N=0, then release with KEY_COL=4'hF -> KEY_ROW sequence 1110,1101,1011,0111 each held 4 cycles; KEY_VALID stays 0; KEY_VALUE=0.
- Single press: pull KEY_COL[2] low whenever KEY_ROW=1101 (key 6), held -> exactly one KEY_VALID after the 3rd scan; KEY_VALUE=6, KEY_PRESSED=1. Release -> KEY_PRESSED=0 after 3 clean scans.
- Bounce: key F (row3, col3) asserted for 2 scans, released for 1 scan, then held -> single KEY_VALID only after 3 consecutive scans; KEY_VALUE=F.
- Multi-key: keys 1 and 4 pressed together -> no KEY_VALID, state stays IDLE. Key 4 then released with key 1 held -> KEY_VALUE=1 after 3 scans.
- No rollover: key 0 held (accepted), key 9 added then key 0 released with key 9 still held -> no KEY_VALID until full release. A later key 9 press -> KEY_VALUE=9.
- Reset mid-debounce: assert RST_N=0 during the 2nd scan of PRESS_DB for key A -> outputs at reset values immediately, no KEY_VALID. With KEY_REPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, key 3 held -> KEY_VALID at accept, then at HELD scan 5, 7, 9, and so on.
